// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of fetched instructions with
// PC, PC+4 and branch-prediction bit, decoupling fetch from decode stalls.
module if_id_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FLUSH,
  input  logic               IF_Valid,
  output logic               IF_Ready,
  input  logic [INSTR_W-1:0] Instr1_IF,
  input  logic [ADDR_W-1:0]  Instr_PC_IF,
  input  logic [ADDR_W-1:0]  Instr_PC_Plus4_IF,
  input  logic               Branch_prediction_IN,
  input  logic               ID_Stall,
  output logic               ID_Valid,
  output logic [INSTR_W-1:0] Instr1_OUT,
  output logic [ADDR_W-1:0]  Instr_PC_OUT,
  output logic [ADDR_W-1:0]  Instr_PC_Plus4,
  output logic               Branch_prediction_OUT,
  output logic [CNT_W-1:0]   Count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [ADDR_W-1:0]  pc4_mem   [DEPTH];
  logic               bp_mem    [DEPTH];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               push;
  logic               pop;

  // Status flags come only from the occupancy register, so IF_Ready never
  // sees ID_Stall and a pop on a full queue cannot admit a push that cycle.
  assign IF_Ready = (count != CNT_W'(DEPTH));
  assign ID_Valid = (count != '0);
  assign Count    = count;

  assign push = IF_Valid && IF_Ready;
  assign pop  = ID_Valid && !ID_Stall;

  // Queue state: async clear, then flush, then normal push/pop bookkeeping.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
        pc4_mem[i]   <= '0;
        bp_mem[i]    <= 1'b0;
      end
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= Instr1_IF;
        pc_mem[wr_ptr]    <= Instr_PC_IF;
        pc4_mem[wr_ptr]   <= Instr_PC_Plus4_IF;
        bp_mem[wr_ptr]    <= Branch_prediction_IN;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head read mux; an empty queue presents an all-zero NOP bubble.
  always_comb begin
    Instr1_OUT            = '0;
    Instr_PC_OUT          = '0;
    Instr_PC_Plus4        = '0;
    Branch_prediction_OUT = 1'b0;
    if (ID_Valid) begin
      Instr1_OUT            = instr_mem[rd_ptr];
      Instr_PC_OUT          = pc_mem[rd_ptr];
      Instr_PC_Plus4        = pc4_mem[rd_ptr];
      Branch_prediction_OUT = bp_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             CLK;
  logic             RESET;
  logic             FLUSH;
  logic             IF_Valid;
  logic             IF_Ready;
  logic [31:0]      Instr1_IF;
  logic [31:0]      Instr_PC_IF;
  logic [31:0]      Instr_PC_Plus4_IF;
  logic             Branch_prediction_IN;
  logic             ID_Stall;
  logic             ID_Valid;
  logic [31:0]      Instr1_OUT;
  logic [31:0]      Instr_PC_OUT;
  logic [31:0]      Instr_PC_Plus4;
  logic             Branch_prediction_OUT;
  logic [CNT_W-1:0] Count;

  if_id_queue #(
    .DEPTH(DEPTH),
    .INSTR_W(32),
    .ADDR_W(32),
    .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .FLUSH(FLUSH),
    .IF_Valid(IF_Valid),
    .IF_Ready(IF_Ready),
    .Instr1_IF(Instr1_IF),
    .Instr_PC_IF(Instr_PC_IF),
    .Instr_PC_Plus4_IF(Instr_PC_Plus4_IF),
    .Branch_prediction_IN(Branch_prediction_IN),
    .ID_Stall(ID_Stall),
    .ID_Valid(ID_Valid),
    .Instr1_OUT(Instr1_OUT),
    .Instr_PC_OUT(Instr_PC_OUT),
    .Instr_PC_Plus4(Instr_PC_Plus4),
    .Branch_prediction_OUT(Branch_prediction_OUT),
    .Count(Count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        bp;
  } ent_t;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic in_reset = 1'b1;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_id_valid"}, 64'(ID_Valid), 64'd0);
    chk({tag, "_if_ready"}, 64'(IF_Ready), 64'd1);
    chk({tag, "_count"},    64'(Count), 64'd0);
    chk({tag, "_instr"},    64'(Instr1_OUT), 64'd0);
    chk({tag, "_pc"},       64'(Instr_PC_OUT), 64'd0);
    chk({tag, "_pc4"},      64'(Instr_PC_Plus4), 64'd0);
    chk({tag, "_bp"},       64'(Branch_prediction_OUT), 64'd0);
  endtask

  // One cycle of stimulus, entered and left at posedge+1. The model entry is
  // appended after the edge the push happens on; the monitor removes pops.
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic bp, input logic stall, input logic flush);
    ent_t e;
    logic accept;
    IF_Valid             = v;
    Instr1_IF            = instr;
    Instr_PC_IF          = pc;
    Instr_PC_Plus4_IF    = pc + 32'd4;
    Branch_prediction_IN = bp;
    ID_Stall             = stall;
    FLUSH                = flush;
    accept = v && !flush && (exp_q.size() != DEPTH);
    e.instr = instr;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    e.bp    = bp;
    @(posedge CLK);
    if (flush) exp_q.delete();
    else if (accept) exp_q.push_back(e);
    #1;
  endtask

  // Monitor: compare head and status against the model; consume on pop.
  always @(negedge CLK) begin
    if (!in_reset) begin
      chk("count", 64'(Count), 64'(exp_q.size()));
      chk("if_ready", 64'(IF_Ready), 64'(exp_q.size() != DEPTH));
      if (exp_q.size() == 0) begin
        chk("id_valid_empty", 64'(ID_Valid), 64'd0);
        chk("empty_instr", 64'(Instr1_OUT), 64'd0);
        chk("empty_pc", 64'(Instr_PC_OUT), 64'd0);
        chk("empty_pc4", 64'(Instr_PC_Plus4), 64'd0);
        chk("empty_bp", 64'(Branch_prediction_OUT), 64'd0);
      end else begin
        chk("id_valid", 64'(ID_Valid), 64'd1);
        chk("head_instr", 64'(Instr1_OUT), 64'(exp_q[0].instr));
        chk("head_pc", 64'(Instr_PC_OUT), 64'(exp_q[0].pc));
        chk("head_pc4", 64'(Instr_PC_Plus4), 64'(exp_q[0].pc4));
        chk("head_bp", 64'(Branch_prediction_OUT), 64'(exp_q[0].bp));
        if (!ID_Stall) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held low with random inputs
    RESET = 1'b0;
    repeat (3) begin
      IF_Valid             = 1'($urandom);
      FLUSH                = 1'($urandom);
      ID_Stall             = 1'($urandom);
      Instr1_IF            = $urandom;
      Instr_PC_IF          = $urandom;
      Instr_PC_Plus4_IF    = $urandom;
      Branch_prediction_IN = 1'($urandom);
      @(negedge CLK);
      chk_reset_outputs("reset");
    end
    IF_Valid = 1'b0;
    FLUSH    = 1'b0;
    ID_Stall = 1'b1;
    @(posedge CLK);
    #2 RESET = 1'b1;
    in_reset = 1'b0;
    @(posedge CLK);
    #1;

    // Fill to capacity with decode stalled; fifth push must be refused
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'b0, 1'b1, 1'b0);
    chk("fill_count", 64'(Count), 64'd4);
    chk("fill_if_ready", 64'(IF_Ready), 64'd0);
    step(1'b1, 32'h1004, 32'h10, 1'b0, 1'b1, 1'b0);
    chk("full_count", 64'(Count), 64'd4);
    chk("full_head_pc", 64'(Instr_PC_OUT), 64'h0);
    chk("full_head_pc4", 64'(Instr_PC_Plus4), 64'h4);

    // Drain
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("drain_id_valid", 64'(ID_Valid), 64'd0);
    chk("drain_pc", 64'(Instr_PC_OUT), 64'd0);

    // Streaming across pointer wrap at constant occupancy 2
    step(1'b1, 32'h2000, 32'h100, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h2001, 32'h104, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h2002 + 32'(i), 32'h108 + 32'(i * 4), ((i % 2) == 0), 1'b0, 1'b0);
      chk("stream_count", 64'(Count), 64'd2);
    end

    // Flush with a simultaneous push
    step(1'b1, 32'h3000, 32'h200, 1'b1, 1'b1, 1'b0);
    chk("preflush_count", 64'(Count), 64'd3);
    step(1'b1, 32'h3001, 32'h40, 1'b0, 1'b0, 1'b1);
    chk("flush_count", 64'(Count), 64'd0);
    chk("flush_id_valid", 64'(ID_Valid), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_no_0x40", 64'(Instr_PC_OUT != 32'h40), 64'd1);

    // Asynchronous reset between edges
    step(1'b1, 32'h4000, 32'h300, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h4001, 32'h304, 1'b0, 1'b1, 1'b0);
    #2;
    in_reset = 1'b1;
    RESET    = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outputs("async_reset");
    IF_Valid = 1'b0;
    FLUSH    = 1'b0;
    @(posedge CLK);
    #2 RESET = 1'b1;
    in_reset = 1'b0;
    @(posedge CLK);
    #1;
    step(1'b1, 32'h5000, 32'h400, 1'b1, 1'b1, 1'b0);
    chk("post_reset_valid", 64'(ID_Valid), 64'd1);
    chk("post_reset_pc", 64'(Instr_PC_OUT), 64'h400);
    chk("post_reset_count", 64'(Count), 64'd1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 70), $urandom, $urandom, 1'($urandom),
           ($urandom_range(0, 99) < 40), ($urandom_range(0, 49) == 0));

    // Final drain
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("final_empty", 64'(ID_Valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction queue between the fetch (IF) and decode (ID) stages, replacing the single-entry IF/ID latch. It buffers up to DEPTH fetched instructions, each with its PC, PC+4 and branch-prediction bit. IF can keep fetching while ID stalls, until the queue fills. FLUSH (branch mispredict or redirect) empties the queue in one cycle.

## Interface
- DEPTH, 4: number of entries; power of two, 2 to 16.
- INSTR_W, 32: instruction width.
- ADDR_W, 32: PC width.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous flush, highest priority after RESET.
- IF_Valid  in  1  IF presents an entry this cycle.
- IF_Ready  out  1  queue can accept an entry.
- Instr1_IF  in  INSTR_W  fetched instruction.
- Instr_PC_IF  in  ADDR_W  address of the fetched instruction.
- Instr_PC_Plus4_IF  in  ADDR_W  address of the next instruction.
- Branch_prediction_IN  in  1  prediction bit from IF.
- ID_Stall  in  1  ID cannot consume the head entry this cycle.
- ID_Valid  out  1  head entry is valid.
- Instr1_OUT  out  INSTR_W  head instruction.
- Instr_PC_OUT  out  ADDR_W  head PC.
- Instr_PC_Plus4  out  ADDR_W  head PC+4.
- Branch_prediction_OUT  out  1  head prediction bit.
- Count  out  CNT_W  current occupancy, 0 to DEPTH.

## Operation
- Storage is a circular buffer of DEPTH entries: {instr, pc, pc4, bp}.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
- Occupancy is held in a separate counter, Count.
- Push: IF_Valid && IF_Ready. Writes the entry at wr_ptr; wr_ptr advances by 1.
- Pop: ID_Valid && !ID_Stall. rd_ptr advances by 1.
- IF_Ready = (Count != DEPTH).
  - IF_Ready depends only on registered state, never on ID_Stall.
  - When the queue is full, a same-cycle pop does not open a slot for a push in that cycle.
- ID_Valid = (Count != 0).
- Head outputs show the entry at rd_ptr while ID_Valid=1.
  - When the queue is empty, all head outputs are forced to 0. Instruction 0 is a NOP bubble.
- Count update per cycle:
  - Count+1 on push only.
  - Count-1 on pop only.
  - Unchanged on both or neither.
- Entries leave in strict FIFO order; payload is not modified.
- FLUSH=1 at a rising edge:
  - Count, wr_ptr and rd_ptr go to 0.
  - Any push or pop in that cycle is discarded.
  - Storage contents need not be cleared; outputs read 0 because the queue is empty.
- RESET low, at any time including mid-operation:
  - Immediately clears Count, both pointers and all storage.
  - All outputs go to 0, except IF_Ready, which is 1.
- IF_Valid=1 while IF_Ready=0: the entry is not taken. IF must hold it and present it again.

## Timing
- Push-to-output latency: 1 cycle. An entry pushed at edge N is visible on the head outputs after edge N, provided it is at the head.
- No combinational path from IF inputs to ID outputs.
- No combinational path from ID_Stall to IF_Ready.
- Head outputs, ID_Valid, IF_Ready and Count derive only from registers, plus read-mux logic.
- Full throughput: one push and one pop per cycle when 0 < Count < DEPTH.
- Empty queue, push and no pop: Count becomes 1; ID_Valid rises the next cycle.
- Full queue: IF_Ready=0. After a pop, IF_Ready returns to 1 the cycle after that edge.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Reset values:
  - Count=0, ID_Valid=0, IF_Ready=1.
  - Instr1_OUT=0, Instr_PC_OUT=0, Instr_PC_Plus4=0, Branch_prediction_OUT=0.

## Test plan
- Reset: hold RESET low with random inputs. Required: ID_Valid=0, IF_Ready=1, Count=0, all head outputs 0.
- Fill (DEPTH=4): ID_Stall=1; push PCs 0x00, 0x04, 0x08, 0x0C, 0x10. Required: Count reaches 4; IF_Ready=0 after the 4th push; 0x10 is not accepted. Head stays PC 0x00, Instr_PC_Plus4=0x04.
- Drain: then set ID_Stall=0 with IF_Valid=0. Required: PCs 0x00, 0x04, 0x08, 0x0C appear on 4 consecutive cycles; then ID_Valid=0 and outputs 0.
- Streaming with wrap-around: push and pop every cycle for 10 entries, starting from Count=2. Required: Count stays 2; order is preserved across pointer wrap; bp bit pattern 1,0,1,... is preserved.
- Flush with simultaneous push: Count=3, FLUSH=1 with IF_Valid=1 and PC 0x40. Required: next cycle Count=0 and ID_Valid=0. PC 0x40 never appears.
- Reset mid-operation: Count=2, assert RESET asynchronously between edges. Required: outputs go to reset values immediately, without waiting for a clock edge. After release, the first push is visible 1 cycle later.
